// File: rtl/collision_detector.sv
// collision_detector: detects pixels where two game objects are drawn together,
// debounces each overlap pair with a per-frame pixel-count threshold, emits one-shot
// hit pulses, and publishes a per-frame collision summary plus the first bird-contact
// coordinate of the previous frame.
module collision_detector #(
   parameter int unsigned HIT_THRESHOLD = 8,
   parameter int unsigned COORD_W       = 11
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               startOfFrame,
   input  logic               enable,
   input  logic [COORD_W-1:0] pixelX,
   input  logic [COORD_W-1:0] pixelY,
   input  logic               birdDR,
   input  logic               pigDR,
   input  logic               woodDR,
   input  logic               boxDR,
   input  logic               groundDR,
   output logic [5:0]         hitPulse,
   output logic [5:0]         frameHits,
   output logic               frameValid,
   output logic [COORD_W-1:0] birdHitX,
   output logic [COORD_W-1:0] birdHitY
);

   localparam int unsigned NUM_PAIRS = 6;
   localparam int unsigned CNT_W     = 8;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] THRESH  = CNT_W'(HIT_THRESHOLD);

   typedef enum logic {
      WAIT_SOF = 1'b0,
      ACTIVE   = 1'b1
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   // Per-pair overlap counters and sticky hit flags for the frame in progress
   logic [NUM_PAIRS-1:0][CNT_W-1:0] r_cnt;
   logic [NUM_PAIRS-1:0][CNT_W-1:0] w_cnt_nxt;
   logic [NUM_PAIRS-1:0]            r_hit;
   logic [NUM_PAIRS-1:0]            w_hit_nxt;
   logic [NUM_PAIRS-1:0]            w_pulse_nxt;

   // First bird-contact pixel of the frame in progress
   logic               r_pend_valid;
   logic               w_pend_valid_nxt;
   logic [COORD_W-1:0] r_pend_x;
   logic [COORD_W-1:0] r_pend_y;
   logic [COORD_W-1:0] w_pend_x_nxt;
   logic [COORD_W-1:0] w_pend_y_nxt;

   // Published outputs
   logic [NUM_PAIRS-1:0] r_hit_pulse;
   logic [NUM_PAIRS-1:0] r_frame_hits;
   logic                 r_frame_valid;
   logic [COORD_W-1:0]   r_bird_hit_x;
   logic [COORD_W-1:0]   r_bird_hit_y;

   logic [NUM_PAIRS-1:0] w_ovl;
   logic [NUM_PAIRS-1:0] w_count;
   logic                 w_counting;
   logic                 w_frame_end;
   logic                 w_clear;
   logic                 w_bird_ovl;

   // Raw pair overlaps: [0]bird-pig [1]bird-wood [2]bird-box [3]bird-ground [4]wood-pig [5]pig-ground
   assign w_ovl[0] = birdDR & pigDR;
   assign w_ovl[1] = birdDR & woodDR;
   assign w_ovl[2] = birdDR & boxDR;
   assign w_ovl[3] = birdDR & groundDR;
   assign w_ovl[4] = woodDR & pigDR;
   assign w_ovl[5] = pigDR  & groundDR;

   // The SOF that leaves WAIT_SOF already counts as pixel 1 of the first frame
   assign w_counting  = enable & ((r_state == ACTIVE) | startOfFrame);
   assign w_frame_end = (r_state == ACTIVE) & startOfFrame;
   assign w_clear     = startOfFrame;
   assign w_count     = w_ovl & {NUM_PAIRS{w_counting}};
   assign w_bird_ovl  = |w_count[3:0];

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= WAIT_SOF;
      else       r_state <= w_state_nxt;
   end

   // FSM next state: ACTIVE is only left through reset
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         WAIT_SOF: if (startOfFrame) w_state_nxt = ACTIVE;
         ACTIVE:   w_state_nxt = ACTIVE;
         default:  w_state_nxt = WAIT_SOF;
      endcase
   end

   // Counter/flag next values: clear on frame boundary first, then count this pixel
   always_comb begin
      w_cnt_nxt   = r_cnt;
      w_hit_nxt   = r_hit;
      w_pulse_nxt = '0;
      for (int i = 0; i < NUM_PAIRS; i++) begin
         if (w_clear) begin
            w_cnt_nxt[i] = '0;
            w_hit_nxt[i] = 1'b0;
         end
         if (w_count[i]) begin
            if (w_cnt_nxt[i] != CNT_MAX) w_cnt_nxt[i] = w_cnt_nxt[i] + CNT_W'(1);
            if ((w_cnt_nxt[i] == THRESH) && !w_hit_nxt[i]) begin
               w_pulse_nxt[i] = 1'b1;
               w_hit_nxt[i]   = 1'b1;
            end
         end
      end
   end

   // Pending bird-contact capture: first bird overlap of the frame wins
   always_comb begin
      w_pend_valid_nxt = w_clear ? 1'b0 : r_pend_valid;
      w_pend_x_nxt     = r_pend_x;
      w_pend_y_nxt     = r_pend_y;
      if (w_bird_ovl && !w_pend_valid_nxt) begin
         w_pend_valid_nxt = 1'b1;
         w_pend_x_nxt     = pixelX;
         w_pend_y_nxt     = pixelY;
      end
   end

   // Frame-in-progress state registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt        <= '0;
         r_hit        <= '0;
         r_pend_valid <= 1'b0;
         r_pend_x     <= '0;
         r_pend_y     <= '0;
      end else begin
         r_cnt        <= w_cnt_nxt;
         r_hit        <= w_hit_nxt;
         r_pend_valid <= w_pend_valid_nxt;
         r_pend_x     <= w_pend_x_nxt;
         r_pend_y     <= w_pend_y_nxt;
      end
   end

   // Output registers: pulses every cycle, summary latched at the end of each complete frame
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hit_pulse   <= '0;
         r_frame_hits  <= '0;
         r_frame_valid <= 1'b0;
         r_bird_hit_x  <= '0;
         r_bird_hit_y  <= '0;
      end else begin
         r_hit_pulse <= w_pulse_nxt;
         if (w_frame_end) begin
            r_frame_hits  <= r_hit;
            r_frame_valid <= 1'b1;
            if (r_pend_valid) begin
               r_bird_hit_x <= r_pend_x;
               r_bird_hit_y <= r_pend_y;
            end
         end
      end
   end

   assign hitPulse   = r_hit_pulse;
   assign frameHits  = r_frame_hits;
   assign frameValid = r_frame_valid;
   assign birdHitX   = r_bird_hit_x;
   assign birdHitY   = r_bird_hit_y;

endmodule
